// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and word width for the serial subtractor.
package cpu_pkg;
  localparam int CPU_WORD_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sersub_state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit difference/borrow cell.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first; SERSUB_FLAGS_EN adds zero/ovf.
module serial_subtractor
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  sersub_state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, diff_q, res;
  logic [CW-1:0] cnt_q;
  logic br_q, bout_q, d, br_d, last;
  full_subtractor u_fs (.x(sa_q[0]), .y(sb_q[0]), .bin(br_q), .d(d), .bout(br_d));
  assign last = cnt_q == CW'(WIDTH - 1);
  assign res = {d, sr_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      sr_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sa_q <= a;
        sb_q <= b;
        br_q <= bin;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        sa_q <= sa_q >> 1;
        sb_q <= sb_q >> 1;
        sr_q <= res;
        br_q <= br_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          diff_q <= res;
          bout_q <= br_d;
        end
      end
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERSUB_FLAGS_EN
  // Operand sign bits are kept since sa/sb are consumed by the shift.
  logic as_q, bs_q, zero_q, ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      as_q <= 1'b0;
      bs_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      as_q <= a[WIDTH-1];
      bs_q <= b[WIDTH-1];
    end else if (state_q == RUN && last) begin
      zero_q <= res == '0;
      ovf_q <= (as_q ^ bs_q) & (d ^ as_q);
    end
  end
  assign zero = zero_q;
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERSUB_FLAGS_EN
  logic zero, ovf;
`endif
  int checks = 0, errors = 0;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERSUB_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin, input bit inject);
    int full, busy_n, done_n, done_k;
    logic [W-1:0] ed, prev;
    logic eb;
    full = int'(oa) - int'(ob) - int'(obin);
    ed = full[W-1:0];
    eb = full < 0;
    prev = diff;
    @(negedge clk);
    a = oa; b = ob; bin = obin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    busy_n = int'(busy); done_n = 0; done_k = 0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      start = inject && (k == 3 || k == 8);
      if (start) begin a = W'($urandom); b = W'($urandom); end
      @(posedge clk); #1;
      busy_n += int'(busy);
      if (done) begin done_n++; done_k = k; end
      if (k == 4) chk("hold_diff", diff, prev);
      if (k == W) begin
        chk("diff", diff, ed);
        chk("bout", bout, eb);
`ifdef SERSUB_FLAGS_EN
        chk("zero", zero, ed == '0);
        chk("ovf", ovf, (oa[W-1] != ob[W-1]) && (ed[W-1] != oa[W-1]));
`endif
      end
    end
    start = 1'b0;
    chk("busy_cycles", busy_n, W);
    chk("done_count", done_n, 1);
    chk("done_latency", done_k, W);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    @(negedge clk); start = 1'b1; a = 8'h05; b = 8'h01;
    @(posedge clk); #1;
    chk("rst_priority", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 0);
    run_op(8'h3C, 8'h3C, 1'b0, 0);
    run_op(8'h3C, 8'h3C, 1'b1, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 1);
    @(negedge clk); a = 8'h99; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    begin
      int dn = 0;
      repeat (W + 2) begin @(posedge clk); #1; dn += int'(done); end
      chk("abort_no_done", dn, 0);
    end
    run_op(8'h10, 8'h01, 1'b0, 0);
    repeat (20) run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
